// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = (a_in - b_in) mod 2^WIDTH over WIDTH RUN cycles.
// Optional signed-overflow output ovf is built when SERSUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done
`ifdef SERSUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, borrow_q;
  logic             a0, b0, d_bit, br_d;
`ifdef SERSUB_SIGNED_OVF_EN
  logic             ovf_q;
`endif

  // One full-subtractor cell fed by the operand LSBs and the stored borrow.
  always_comb begin
    a0    = a_q[0];
    b0    = b_q[0];
    d_bit = a0 ^ b0 ^ br_q;
    br_d  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  end

  assign busy       = (state_q != IDLE);
  assign bit_valid  = (state_q == RUN);
  assign bit_out    = bit_valid & d_bit;
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERSUB_SIGNED_OVF_EN
  assign ovf        = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            br_q    <= 1'b0;
            diff_q  <= '0;
            cnt_q   <= '0;
`ifdef SERSUB_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= {d_bit, diff_q[WIDTH-1:1]};
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          // Last cell: operand MSBs are at bit 0 now, so overflow is judged here.
          if (cnt_q == CW'(WIDTH - 1)) begin
            borrow_q <= br_d;
`ifdef SERSUB_SIGNED_OVF_EN
            ovf_q    <= (a0 ^ b0) & (a0 ^ d_bit);
`endif
            state_q  <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf cases need SERSUB_SIGNED_OVF_EN.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a_in, b_in;
  logic       busy, bit_out, bit_valid, borrow_out, done;
  logic [7:0] diff;
`ifdef SERSUB_SIGNED_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .diff       (diff),
    .borrow_out (borrow_out),
    .done       (done)
`ifdef SERSUB_SIGNED_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single start pulse, then follow the job to its done pulse (bounded).
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_diff, input logic exp_borrow);
    int unsigned nvalid;
    int unsigned cyc;
    logic [7:0]  bits;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start  = 1'b0;
    nvalid = 0;
    cyc    = 1;
    bits   = '0;
    while (!done && cyc < 20) begin
      if (bit_valid) begin
        if (nvalid < 8) bits[nvalid] = bit_out;
        nvalid++;
      end
      tick();
      cyc++;
    end
    check({tag, "_done"},   {31'd0, done}, 32'd1);
    check({tag, "_lat"},    cyc, 32'd9);
    check({tag, "_nvalid"}, nvalid, 32'd8);
    check({tag, "_diff"},   {24'd0, diff}, {24'd0, exp_diff});
    check({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, exp_borrow});
    check({tag, "_serial"}, {24'd0, bits}, {24'd0, exp_diff});
    tick();
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold"},      {24'd0, diff}, {24'd0, exp_diff});
  endtask

  initial begin
    int unsigned cyc;
    int unsigned ndone;
    logic [7:0]  cap;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #1;
    check("rst_busy",   {31'd0, busy},       32'd0);
    check("rst_valid",  {31'd0, bit_valid},  32'd0);
    check("rst_bitout", {31'd0, bit_out},    32'd0);
    check("rst_diff",   {24'd0, diff},       32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
    check("rst_done",   {31'd0, done},       32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 5 - 3: serial stream 0,1,0,0,0,0,0,0
    run_op("t1", 8'h05, 8'h03, 8'h02, 1'b0);

    // 3 - 5 then FF - FF with start held; operands change during RUN must be ignored
    a_in  = 8'h03;
    b_in  = 8'h05;
    start = 1'b1;
    tick();
    a_in = 8'hFF;
    b_in = 8'hFF;
    cyc  = 1;
    while (!done && cyc < 20) begin tick(); cyc++; end
    check("b2b_lat1",    cyc, 32'd9);
    check("b2b_diff1",   {24'd0, diff}, 32'hFE);
    check("b2b_borrow1", {31'd0, borrow_out}, 32'd1);
    tick();
    cyc = 1;
    while (!done && cyc < 20) begin tick(); cyc++; end
    start = 1'b0;
    check("b2b_gap",     cyc, 32'd10);
    check("b2b_diff2",   {24'd0, diff}, 32'h00);
    check("b2b_borrow2", {31'd0, borrow_out}, 32'd0);
    tick();
    tick();

    // Start during RUN cycle 3 with a new minuend must be ignored
    a_in  = 8'h10;
    b_in  = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a_in  = 8'hAA;
    tick();
    start = 1'b0;
    ndone = 0;
    cap   = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin ndone++; cap = diff; end
      tick();
    end
    check("ign_ndone", ndone, 32'd1);
    check("ign_diff",  {24'd0, cap}, 32'h0F);

    // 0 - 1: all-ones result with borrow
    run_op("t3", 8'h00, 8'h01, 8'hFF, 1'b1);

    // Reset at RUN cycle 4 aborts asynchronously
    a_in  = 8'h33;
    b_in  = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy",   {31'd0, busy},       32'd0);
    check("abort_valid",  {31'd0, bit_valid},  32'd0);
    check("abort_diff",   {24'd0, diff},       32'd0);
    check("abort_borrow", {31'd0, borrow_out}, 32'd0);
    tick();
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_nodone", ndone, 32'd0);
    run_op("t5", 8'h09, 8'h04, 8'h05, 1'b0);

`ifdef SERSUB_SIGNED_OVF_EN
    run_op("ovf1", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("ovf1_flag", {31'd0, ovf}, 32'd1);
    run_op("ovf0", 8'h7F, 8'h01, 8'h7E, 1'b0);
    check("ovf0_flag", {31'd0, ovf}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
